// File: rtl/spi_cmd_receiver_pkg.sv
// Shared definitions for the SPI command receiver and the command decoder.
// The default field widths here must match the decoder's view of a frame.
package spi_cmd_receiver_pkg;

  localparam int CMD_WIDTH_DEF      = 8;
  localparam int DATAWORD_WIDTH_DEF = 16;
  localparam int FRAME_LEN          = CMD_WIDTH_DEF + DATAWORD_WIDTH_DEF;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } rx_state_e;

endpackage

// File: rtl/spi_cmd_receiver_if.sv
// SPI pins plus the decoded command outputs.
// The receiver is the SPI slave; the host/decoder side uses the master modport.
interface spi_cmd_receiver_if
  import spi_cmd_receiver_pkg::*;
#(
  parameter int CMD_WIDTH      = CMD_WIDTH_DEF,
  parameter int DATAWORD_WIDTH = DATAWORD_WIDTH_DEF
);

  logic                      spi_sclk;
  logic                      spi_cs_n;
  logic                      spi_mosi;
  logic                      spi_miso;
  logic [CMD_WIDTH-1:0]      cmd_word;
  logic [DATAWORD_WIDTH-1:0] data_word;
  logic                      cmd_valid;
  logic                      frame_err;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  spi_miso, cmd_word, data_word, cmd_valid, frame_err
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output spi_miso, cmd_word, data_word, cmd_valid, frame_err
  );

endinterface

// File: rtl/spi_cmd_receiver_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with a history flop
// so the synchronized level can be turned into single-cycle edge strobes.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;

  // synchronizer chain and edge-history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{RESET_VAL}};
      hist_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      hist_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~hist_r;
  assign fall  = ~sync_r[STAGES-1] & hist_r;

endmodule

// File: rtl/spi_cmd_receiver.sv
// SPI mode-0 slave that deserializes {cmd, data} frames into sys_clk and
// echoes the previous valid frame on MISO.
module spi_cmd_receiver
  import spi_cmd_receiver_pkg::*;
#(
  parameter int CMD_WIDTH      = CMD_WIDTH_DEF,
  parameter int DATAWORD_WIDTH = DATAWORD_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input logic               sys_clk,
  input logic               sys_rst,
  spi_cmd_receiver_if.slave bus
);

  localparam int F     = CMD_WIDTH + DATAWORD_WIDTH;
  localparam int CNT_W = $clog2(F + 1);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;

  // all three pins reset low, so CS reads as asserted until it is really seen high
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(sys_clk), .rst(sys_rst), .din(bus.spi_sclk),
    .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk(sys_clk), .rst(sys_rst), .din(bus.spi_cs_n),
    .level(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s));
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(sys_clk), .rst(sys_rst), .din(bus.spi_mosi),
    .level(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s));

  logic sync_unused_s;
  assign sync_unused_s = &{1'b0, sclk_lvl_s, mosi_rise_s, mosi_fall_s};

  rx_state_e                 state_r, state_nxt_s;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
  logic [F-1:0]              rx_r, rx_nxt_s;
  logic [F-1:0]              tx_r, tx_nxt_s;
  logic [CMD_WIDTH-1:0]      cmd_word_r;
  logic [DATAWORD_WIDTH-1:0] data_word_r;
  logic                      cmd_valid_r, frame_err_r, miso_r;
  logic                      done_s, abort_s;

  // next state, counter and shift-register updates
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rx_nxt_s    = rx_r;
    tx_nxt_s    = tx_r;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        if (cs_lvl_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_IDLE;
        end
      end
      IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = '0;
          tx_nxt_s    = {cmd_word_r, data_word_r};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        // a CS release in the same cycle as an SCLK rise discards that bit
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
          abort_s     = 1'b1;
        end else if (sclk_rise_s) begin
          rx_nxt_s  = {rx_r[F-2:0], mosi_lvl_s};
          cnt_nxt_s = cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(F - 1)) begin
            state_nxt_s = DONE;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else if (sclk_fall_s) begin
          tx_nxt_s = {tx_r[F-2:0], 1'b0};
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (cs_rise_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = WAIT_IDLE;
      end
    endcase
  end

  // state, datapath and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r     <= WAIT_IDLE;
      cnt_r       <= '0;
      rx_r        <= '0;
      tx_r        <= '0;
      cmd_word_r  <= '0;
      data_word_r <= '0;
      cmd_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      miso_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rx_r        <= rx_nxt_s;
      tx_r        <= tx_nxt_s;
      cmd_valid_r <= done_s;
      frame_err_r <= abort_s;
      miso_r      <= (state_nxt_s == SHIFT) ? tx_nxt_s[F-1] : 1'b0;
      if (done_s) begin
        cmd_word_r  <= rx_nxt_s[F-1 -: CMD_WIDTH];
        data_word_r <= rx_nxt_s[DATAWORD_WIDTH-1:0];
      end
    end
  end

  assign bus.spi_miso  = miso_r;
  assign bus.cmd_word  = cmd_word_r;
  assign bus.data_word = data_word_r;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: doc/spi_cmd_receiver.md
# spi_cmd_receiver

SPI slave front end for the synthesizer command path. It accepts framed SPI transactions (mode 0, MSB first) on asynchronous pins, synchronizes them into `sys_clk`, and deserializes each frame into an 8-bit command word and a 16-bit data word. A complete frame produces a one-cycle `cmd_valid` pulse, which the command decoder consumes directly. On `spi_miso` it echoes the previously received frame for host readback.

## Interface
Parameters:
- `CMD_WIDTH`, 8: command field width (first bits on the wire).
- `DATAWORD_WIDTH`, 16: data field width (follows the command field).
- `SYNC_STAGES`, 2: synchronizer depth for `spi_sclk`, `spi_cs_n` and `spi_mosi`; minimum 2.

Ports:
- `sys_clk` in 1: system clock. One clock; all logic is on its rising edge.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `spi_sclk` in 1: SPI clock, asynchronous to `sys_clk`.
- `spi_cs_n` in 1: chip select, active-low, asynchronous.
- `spi_mosi` in 1: serial data in, asynchronous.
- `spi_miso` out 1: serial readback out.
- `cmd_word` out CMD_WIDTH: last valid command field.
- `data_word` out DATAWORD_WIDTH: last valid data field.
- `cmd_valid` out 1: one-cycle pulse when `cmd_word` and `data_word` are updated.
- `frame_err` out 1: one-cycle pulse when a frame is aborted short.

## Operation
- **Frame length:** F = CMD_WIDTH + DATAWORD_WIDTH (24 by default). Frame layout is `{cmd, data}`, MSB first.
- **Synchronizers:** all three pins pass through SYNC_STAGES flops, followed by one history flop used for edge detection.
  - Reset values: `sclk` 0, `mosi` 0, `cs_n` 0 (asserted). This forces a genuine CS high before the first frame is accepted.
- **Edge events** (derived from the synchronized signals):
  - `sclk_rise`, `sclk_fall`
  - `cs_fall`: CS becomes active.
  - `cs_rise`: CS becomes inactive.
- **FSM states:** WAIT_IDLE (reset state), IDLE, SHIFT, DONE.
  - WAIT_IDLE → IDLE when synchronized `cs_n` is 1.
  - IDLE → SHIFT on `cs_fall`. On the same edge: clear the bit counter and load the tx shift register with the last valid `{cmd_word, data_word}`.
  - In SHIFT, each `sclk_rise` shifts synchronized `mosi` into the rx register LSB and increments the counter (5 bits).
  - SHIFT → DONE when the F-th bit is shifted. On that transition, register `cmd_word` and `data_word` from rx and pulse `cmd_valid`.
  - SHIFT → IDLE on `cs_rise` with counter < F. Pulse `frame_err`; `cmd_word` and `data_word` remain unchanged.
  - DONE → IDLE on `cs_rise`. `sclk` edges in DONE are ignored, so extra bits are neither captured nor an error.
- **MISO:** `spi_miso` is the tx register MSB.
  - The tx register shifts left on `sclk_fall` in SHIFT.
  - Outside SHIFT, `spi_miso` is 0.
  - Readback before any valid frame is all zeros.
- **Simultaneous `cs_rise` and `sclk_rise`:** `cs_rise` wins and the bit is discarded.
- **Reset mid-frame:** all state returns to reset values. The rest of the in-flight frame is ignored until CS is seen high (WAIT_IDLE).

## Timing
- **Reset values:** `cmd_word` 0, `data_word` 0, `cmd_valid` 0, `frame_err` 0, `spi_miso` 0.
- **Latency:** `cmd_valid` rises SYNC_STAGES + 2 `sys_clk` cycles after the pin-level rising edge of the F-th `sclk` (±1 for sampling phase). `cmd_word` and `data_word` are valid in the same cycle as the pulse and hold until the next valid frame.
- **`frame_err` latency:** same as `cmd_valid`, measured from the pin-level CS rise.
- **External timing requirements:**
  - `sclk` high and low times ≥ SYNC_STAGES + 2 `sys_clk` periods each.
  - CS-fall-to-first-`sclk`-rise ≥ SYNC_STAGES + 3 periods, so the first MISO bit is valid when sampled.
  - CS high time between frames ≥ SYNC_STAGES + 2 periods.
  - `mosi` stable around the `sclk` rise for ≥ 1 period.
- **MISO timing:** `spi_miso` changes SYNC_STAGES + 2 cycles after a pin-level `sclk` fall, which is within the low phase.

## Structure
- The shared package holds:
  - FSM state enum (WAIT_IDLE, IDLE, SHIFT, DONE).
  - Frame length constant F.
  - Default `CMD_WIDTH` and `DATAWORD_WIDTH`, which must match the command decoder.
- One sub-module, `sync_edge`: a parameterized SYNC_STAGES synchronizer with reset value and history flop, outputting level, rise and fall. Instantiate it three times.
- The top level holds the FSM, counter, rx and tx shift registers, and output registers.

## Test plan
- **Single frame:** frame 0x22_1234 at sclk = sys_clk/10 → exactly one `cmd_valid` pulse, `cmd_word` = 0x22, `data_word` = 0x1234, `frame_err` stays 0.
- **Short frame:** 10 bits, then CS high → one `frame_err` pulse, no `cmd_valid`, outputs keep their previous values.
- **Long frame:** 30 bits, first 24 = 0x81_0FFF → one `cmd_valid` after bit 24 with `cmd_word` 0x81 and `data_word` 0x0FFF; trailing bits ignored, no `frame_err`.
- **Readback:** frame 0x22_1234, then frame 0x00_0000 → MISO during the second frame reads 0x221234 MSB first; MISO during the first frame reads 0x000000.
- **Reset mid-frame:** assert `sys_rst` after 12 bits with CS held low and clocking continuing → no `cmd_valid` or `frame_err` for that frame; after CS high, frame 0x10_0ABC is accepted correctly.
- **Back-to-back frames:** frames with minimum CS high gap (SYNC_STAGES + 2 cycles) → two `cmd_valid` pulses, each with correct data.
